ps2_cmd_ctrl: RTL and testbench

- Host-side command sequencer for the PS/2 port. It owns the shared PS/2 lines.
- Gates the receiver (rx_en) and fires the transmitter, one byte at a time.
- Sends a command byte, plus an optional argument byte, and waits for the device ACK (0xFA). Retries on resend (0xFE) and times out if the device goes silent.
- Outside command transactions, received bytes pass through as scan data.
- Sits between the PS/2 rx/tx datapaths and the system-side command interface.

---
 rtl/ps2_cmd_ctrl_if.sv | 24 ++
 rtl/ps2_cmd_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ps2_cmd_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_cmd_ctrl_if.sv
// System-side command interface of the PS/2 command sequencer.
// master = command requester, slave = ps2_cmd_ctrl.
interface ps2_cmd_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_has_arg;
  logic [7:0] cmd_arg;
  logic       resp_valid;
  logic [1:0] resp_code;
  logic       busy;
  logic       scan_valid;
  logic [7:0] scan_data;

  modport master (
    output cmd_valid, cmd_data, cmd_has_arg, cmd_arg,
    input  cmd_ready, resp_valid, resp_code, busy, scan_valid, scan_data
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_has_arg, cmd_arg,
    output cmd_ready, resp_valid, resp_code, busy, scan_valid, scan_data
  );
endinterface

// File: rtl/ps2_cmd_ctrl.sv
// Host-side PS/2 command sequencer: sends command (+ optional argument), handles ACK/resend/timeout.
// Define PS2_ECHO_DETECT_EN to accept an 0xEE reply as the ACK of an 0xEE (echo) command.
module ps2_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned TMR_W          = 22,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic          clk,
  input  logic          reset,
  ps2_cmd_ctrl_if.slave cmd,
  output logic          rx_en,
  input  logic          rx_done,
  input  logic [7:0]    rx_data,
  output logic          wr_ps2,
  output logic [7:0]    tx_din,
  input  logic          tx_idle,
  input  logic          tx_done
);
  localparam logic [7:0] ByteAck    = 8'hFA;
  localparam logic [7:0] ByteResend = 8'hFE;
  localparam logic [7:0] ByteErr    = 8'hFC;
  localparam logic [7:0] ByteEcho   = 8'hEE;

  localparam logic [1:0] RespOk      = 2'b00;
  localparam logic [1:0] RespNak     = 2'b01;
  localparam logic [1:0] RespErr     = 2'b10;
  localparam logic [1:0] RespTimeout = 2'b11;

  localparam logic [1:0]       MaxRetry  = 2'(MAX_RETRY);
  localparam logic [TMR_W-1:0] TimerLast = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StSend, StWaitTx, StWaitAck, StResp} state_e;
  typedef enum logic {PhCmd, PhArg} phase_e;

  state_e           state_q;
  phase_e           phase_q;
  logic [7:0]       cmd_q;
  logic [7:0]       arg_q;
  logic             has_arg_q;
  logic [1:0]       retry_q;
  logic [TMR_W-1:0] timer_q;
  logic             resp_valid_q;
  logic [1:0]       resp_code_q;
  logic             scan_valid_q;
  logic [7:0]       scan_data_q;

  logic       accept;
  logic       timeout;
  logic       is_ack;
  logic       has_arg_in;
  logic [7:0] cur_byte;

  assign cmd.cmd_ready  = (state_q == StIdle) & tx_idle;
  assign cmd.busy       = (state_q != StIdle);
  assign cmd.resp_valid = resp_valid_q;
  assign cmd.resp_code  = resp_code_q;
  assign cmd.scan_valid = scan_valid_q;
  assign cmd.scan_data  = scan_data_q;
  assign rx_en          = ((state_q == StIdle) | (state_q == StWaitAck)) & tx_idle;

  assign accept   = cmd.cmd_valid & cmd.cmd_ready;
  assign timeout  = (timer_q == TimerLast);
  assign cur_byte = (phase_q == PhCmd) ? cmd_q : arg_q;

`ifdef PS2_ECHO_DETECT_EN
  assign is_ack     = (rx_data == ByteAck) | ((cmd_q == ByteEcho) & (rx_data == ByteEcho));
  assign has_arg_in = cmd.cmd_has_arg & (cmd.cmd_data != ByteEcho);
`else
  assign is_ack     = (rx_data == ByteAck);
  assign has_arg_in = cmd.cmd_has_arg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      phase_q      <= PhCmd;
      cmd_q        <= '0;
      arg_q        <= '0;
      has_arg_q    <= 1'b0;
      retry_q      <= '0;
      timer_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_code_q  <= RespOk;
      scan_valid_q <= 1'b0;
      scan_data_q  <= '0;
      wr_ps2       <= 1'b0;
      tx_din       <= '0;
    end else begin
      wr_ps2       <= 1'b0;
      resp_valid_q <= 1'b0;
      scan_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx_done) begin
            scan_valid_q <= 1'b1;
            scan_data_q  <= rx_data;
          end
          if (accept) begin
            cmd_q     <= cmd.cmd_data;
            arg_q     <= cmd.cmd_arg;
            has_arg_q <= has_arg_in;
            phase_q   <= PhCmd;
            retry_q   <= '0;
            state_q   <= StSend;
          end
        end
        StSend: begin
          wr_ps2  <= 1'b1;
          tx_din  <= cur_byte;
          timer_q <= '0;
          state_q <= StWaitTx;
        end
        StWaitTx: begin
          timer_q <= timer_q + 1'b1;
          if (timeout) begin
            resp_valid_q <= 1'b1;
            resp_code_q  <= RespTimeout;
            state_q      <= StResp;
          end else if (tx_done) begin
            state_q <= StWaitAck;
          end
        end
        StWaitAck: begin
          timer_q <= timer_q + 1'b1;
          // A decisive reply byte takes priority over a coincident timeout.
          if (rx_done && is_ack) begin
            if ((phase_q == PhCmd) && has_arg_q) begin
              phase_q <= PhArg;
              retry_q <= '0;
              state_q <= StSend;
            end else begin
              resp_valid_q <= 1'b1;
              resp_code_q  <= RespOk;
              state_q      <= StResp;
            end
          end else if (rx_done && (rx_data == ByteResend)) begin
            if (retry_q < MaxRetry) begin
              retry_q <= retry_q + 1'b1;
              state_q <= StSend;
            end else begin
              resp_valid_q <= 1'b1;
              resp_code_q  <= RespNak;
              state_q      <= StResp;
            end
          end else if (rx_done && (rx_data == ByteErr)) begin
            resp_valid_q <= 1'b1;
            resp_code_q  <= RespErr;
            state_q      <= StResp;
          end else begin
            if (rx_done) begin
              scan_valid_q <= 1'b1;
              scan_data_q  <= rx_data;
            end
            if (timeout) begin
              resp_valid_q <= 1'b1;
              resp_code_q  <= RespTimeout;
              state_q      <= StResp;
            end
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Self-checking bench for ps2_cmd_ctrl: table of command transactions against a
// scripted device, plus directed idle-scan, timeout-latency and mid-transaction reset cases.
module tb_ps2_cmd_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       rx_en;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       wr_ps2;
  logic [7:0] tx_din;
  logic       tx_idle;
  logic       tx_done;

  ps2_cmd_ctrl_if cif ();

  ps2_cmd_ctrl #(
    .TIMEOUT_CYCLES(100),
    .TMR_W         (7),
    .MAX_RETRY     (3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .cmd    (cif),
    .rx_en  (rx_en),
    .rx_done(rx_done),
    .rx_data(rx_data),
    .wr_ps2 (wr_ps2),
    .tx_din (tx_din),
    .tx_idle(tx_idle),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]      cmd;
    logic            has_arg;
    logic [7:0]      arg;
    int              n_rep;
    logic [0:7][7:0] rep;
    logic [1:0]      exp_code;
    int              exp_wr;
    int              exp_scan;
    logic [7:0]      exp_last_tx;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic       got;
  logic [1:0] resp;
  int         wr_cnt;
  int         scan_cnt;
  int         lat;
  logic [7:0] first_tx;
  logic [7:0] last_tx;
  vec_t       vecs [8];
  vec_t       tv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one command and plays the device: tx completes 3 cycles after wr_ps2,
  // replies come 2 cycles after tx_done (3 cycles after a non-decisive reply).
  task automatic run_txn(input vec_t v);
    int idx, tx_cnt, rep_wait, first_wr, cyc;
    logic [7:0] b;
    idx = 0; tx_cnt = 0; rep_wait = 0; first_wr = 0; cyc = 0;
    got = 1'b0; wr_cnt = 0; scan_cnt = 0; lat = -1; first_tx = '0; last_tx = '0;
    cif.cmd_valid   = 1'b1;
    cif.cmd_data    = v.cmd;
    cif.cmd_has_arg = v.has_arg;
    cif.cmd_arg     = v.arg;
    while (!got && cyc < 600) begin
      tick();
      cyc++;
      rx_done = 1'b0;
      tx_done = 1'b0;
      if (cif.busy) cif.cmd_valid = 1'b0;
      if (cif.scan_valid) scan_cnt++;
      if (cif.resp_valid) begin
        got  = 1'b1;
        resp = cif.resp_code;
        lat  = cyc - first_wr;
      end
      if (wr_ps2) begin
        if (wr_cnt == 0) begin
          first_wr = cyc;
          first_tx = tx_din;
        end
        last_tx = tx_din;
        wr_cnt++;
        tx_idle = 1'b0;
        tx_cnt  = 3;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          tx_done  = 1'b1;
          tx_idle  = 1'b1;
          rep_wait = 2;
        end
      end else if (rep_wait > 0) begin
        rep_wait--;
        if (rep_wait == 0 && idx < v.n_rep) begin
          b       = v.rep[idx];
          rx_done = 1'b1;
          rx_data = b;
          idx++;
          if (b != 8'hFA && b != 8'hFE && b != 8'hFC) rep_wait = 3;
        end
      end
    end
    cif.cmd_valid = 1'b0;
    rx_done       = 1'b0;
    tx_done       = 1'b0;
    tx_idle       = 1'b1;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: actual=hang required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{cmd: 8'hED, has_arg: 1'b1, arg: 8'h07, n_rep: 2,
                rep: {8'hFA, 8'hFA, 48'h0},
                exp_code: 2'b00, exp_wr: 2, exp_scan: 0, exp_last_tx: 8'h07};
    vecs[1] = '{cmd: 8'hF4, has_arg: 1'b0, arg: 8'h00, n_rep: 4,
                rep: {8'hFE, 8'hFE, 8'hFE, 8'hFE, 32'h0},
                exp_code: 2'b01, exp_wr: 4, exp_scan: 0, exp_last_tx: 8'hF4};
    vecs[2] = '{cmd: 8'hF3, has_arg: 1'b1, arg: 8'h20, n_rep: 3,
                rep: {8'h1C, 8'hFA, 8'hFC, 40'h0},
                exp_code: 2'b10, exp_wr: 2, exp_scan: 1, exp_last_tx: 8'h20};
    vecs[3] = '{cmd: 8'hF4, has_arg: 1'b0, arg: 8'h00, n_rep: 2,
                rep: {8'hFE, 8'hFA, 48'h0},
                exp_code: 2'b00, exp_wr: 2, exp_scan: 0, exp_last_tx: 8'hF4};
    vecs[4] = '{cmd: 8'hF2, has_arg: 1'b1, arg: 8'hAB, n_rep: 3,
                rep: {8'hFA, 8'hFE, 8'hFA, 40'h0},
                exp_code: 2'b00, exp_wr: 3, exp_scan: 0, exp_last_tx: 8'hAB};
    vecs[5] = '{cmd: 8'hED, has_arg: 1'b1, arg: 8'h05, n_rep: 8,
                rep: {8'hFE, 8'hFE, 8'hFE, 8'hFA, 8'hFE, 8'hFE, 8'hFE, 8'hFA},
                exp_code: 2'b00, exp_wr: 8, exp_scan: 0, exp_last_tx: 8'h05};
    vecs[6] = '{cmd: 8'hF4, has_arg: 1'b0, arg: 8'h00, n_rep: 4,
                rep: {8'hFE, 8'hFE, 8'hFE, 8'hFC, 32'h0},
                exp_code: 2'b10, exp_wr: 4, exp_scan: 0, exp_last_tx: 8'hF4};
`ifdef PS2_ECHO_DETECT_EN
    vecs[7] = '{cmd: 8'hEE, has_arg: 1'b0, arg: 8'h00, n_rep: 1,
                rep: {8'hEE, 56'h0},
                exp_code: 2'b00, exp_wr: 1, exp_scan: 0, exp_last_tx: 8'hEE};
`else
    vecs[7] = '{cmd: 8'hEE, has_arg: 1'b0, arg: 8'h00, n_rep: 1,
                rep: {8'hEE, 56'h0},
                exp_code: 2'b11, exp_wr: 1, exp_scan: 1, exp_last_tx: 8'hEE};
`endif

    reset = 1'b1; rx_done = 1'b0; rx_data = '0; tx_idle = 1'b1; tx_done = 1'b0;
    cif.cmd_valid = 1'b0; cif.cmd_data = '0; cif.cmd_has_arg = 1'b0; cif.cmd_arg = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", cif.busy, 0);
    chk("rst_cmd_ready", cif.cmd_ready, 1);
    chk("rst_rx_en", rx_en, 1);
    chk("rst_wr_ps2", wr_ps2, 0);
    chk("rst_resp_valid", cif.resp_valid, 0);
    chk("rst_resp_code", cif.resp_code, 0);
    chk("rst_scan_valid", cif.scan_valid, 0);
    chk("rst_scan_data", cif.scan_data, 0);
    chk("rst_tx_din", tx_din, 0);

    // Idle pass-through of an unsolicited byte.
    rx_done = 1'b1; rx_data = 8'h1C;
    tick();
    rx_done = 1'b0;
    chk("idle_scan_valid", cif.scan_valid, 1);
    chk("idle_scan_data", cif.scan_data, 8'h1C);
    chk("idle_busy", cif.busy, 0);
    chk("idle_wr_ps2", wr_ps2, 0);
    tick();
    chk("idle_scan_pulse_end", cif.scan_valid, 0);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i]);
      chk($sformatf("v%0d_resp_seen", i), got, 1);
      chk($sformatf("v%0d_resp_code", i), resp, vecs[i].exp_code);
      chk($sformatf("v%0d_wr_count", i), wr_cnt, vecs[i].exp_wr);
      chk($sformatf("v%0d_scan_count", i), scan_cnt, vecs[i].exp_scan);
      chk($sformatf("v%0d_first_tx", i), first_tx, vecs[i].cmd);
      chk($sformatf("v%0d_last_tx", i), last_tx, vecs[i].exp_last_tx);
      tick();
      chk($sformatf("v%0d_idle_after", i), cif.busy, 0);
    end

    // Silent device: timeout response exactly 100 cycles after the tx pulse.
    tv = '{cmd: 8'hFF, has_arg: 1'b0, arg: 8'h00, n_rep: 0, rep: 64'h0,
           exp_code: 2'b11, exp_wr: 1, exp_scan: 0, exp_last_tx: 8'hFF};
    run_txn(tv);
    chk("to_resp_seen", got, 1);
    chk("to_resp_code", resp, 2'b11);
    chk("to_latency", lat, 100);
    chk("to_wr_count", wr_cnt, 1);
    tick();
    chk("to_rx_en_idle", rx_en, 1);
    chk("to_busy_idle", cif.busy, 0);

    // Acceptance and rx_done together in IDLE, then reset while in WAIT_ACK.
    cif.cmd_valid = 1'b1; cif.cmd_data = 8'hF4; cif.cmd_has_arg = 1'b0;
    rx_done = 1'b1; rx_data = 8'h55;
    tick();
    rx_done = 1'b0;
    cif.cmd_valid = 1'b0;
    chk("both_scan_valid", cif.scan_valid, 1);
    chk("both_scan_data", cif.scan_data, 8'h55);
    chk("both_busy", cif.busy, 1);
    begin
      int n;
      n = 0;
      while (!wr_ps2 && n < 10) begin
        tick();
        n++;
      end
      chk("rst_seq_wr_seen", wr_ps2, 1);
      chk("rst_seq_tx_din", tx_din, 8'hF4);
    end
    tx_idle = 1'b0;
    tick();
    tick();
    tx_done = 1'b1; tx_idle = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    chk("wait_ack_busy", cif.busy, 1);
    chk("wait_ack_rx_en", rx_en, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", cif.busy, 0);
    chk("midrst_cmd_ready", cif.cmd_ready, tx_idle);
    chk("midrst_resp_valid", cif.resp_valid, 0);
    chk("midrst_wr_ps2", wr_ps2, 0);
    begin
      int pulses;
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
        tick();
        if (cif.resp_valid) pulses++;
      end
      chk("midrst_no_resp", pulses, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
